// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a CPU instruction port and a
// CPU data port. It keeps at most one transaction in flight. Data requests
// normally win arbitration. A saturating starvation counter makes sure a
// waiting instruction fetch is served after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // instruction port
  input  logic        i_inst_read,
  input  logic [31:0] i_inst_addr,
  output logic        o_inst_resp,
  output logic [31:0] o_inst_rdata,
  // data port
  input  logic        i_data_read,
  input  logic        i_data_write,
  input  logic [3:0]  i_data_mbe,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_resp,
  output logic [31:0] o_data_rdata,
  // shared memory port
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [3:0]  o_mem_mbe,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_resp,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_INST = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  state_t      r_state;
  logic [1:0]  r_starve_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mbe;
  logic        r_mem_read;
  logic        r_mem_write;

  logic        w_data_req;
  logic        w_data_wins;
  logic        w_inst_resp;
  logic        w_data_resp;

  assign w_data_req  = i_data_read | i_data_write;
  assign w_data_wins = w_data_req & ((r_starve_cnt < LIMIT) | ~i_inst_read);

  // Arbitration FSM: grant and latch the request in IDLE, hold it until mem_resp.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 2'd0;
      r_addr       <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_mbe        <= 4'h0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_data_wins) begin
            // a simultaneous read+write request is treated as a write
            r_state     <= ST_DATA;
            r_addr      <= i_data_addr;
            r_wdata     <= i_data_wdata;
            r_mbe       <= i_data_write ? i_data_mbe : 4'hF;
            r_mem_read  <= ~i_data_write;
            r_mem_write <= i_data_write;
            if (i_inst_read && (r_starve_cnt < LIMIT)) begin
              r_starve_cnt <= r_starve_cnt + 2'd1;
            end else begin
              r_starve_cnt <= r_starve_cnt;
            end
          end else if (i_inst_read) begin
            r_state      <= ST_INST;
            r_addr       <= i_inst_addr;
            r_wdata      <= 32'h0000_0000;
            r_mbe        <= 4'hF;
            r_mem_read   <= 1'b1;
            r_mem_write  <= 1'b0;
            r_starve_cnt <= 2'd0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_INST, ST_DATA: begin
          // the CPU request may drop; the memory transaction still completes
          if (i_mem_resp) begin
            r_state     <= ST_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Route the memory response to the current owner; mem_resp in IDLE is dropped.
  always_comb begin
    w_inst_resp = 1'b0;
    w_data_resp = 1'b0;
    if (!i_rst && i_mem_resp) begin
      w_inst_resp = (r_state == ST_INST);
      w_data_resp = (r_state == ST_DATA);
    end else begin
      w_inst_resp = 1'b0;
      w_data_resp = 1'b0;
    end
  end

  assign o_inst_resp  = w_inst_resp;
  assign o_data_resp  = w_data_resp;
  assign o_inst_rdata = w_inst_resp ? i_mem_rdata : 32'h0000_0000;
  assign o_data_rdata = w_data_resp ? i_mem_rdata : 32'h0000_0000;

  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_mem_mbe   = r_mbe;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter list SHALL be: STARVE_LIMIT, default 3, the number of consecutive data grants allowed while an instruction request waits.
REQ-002 The ports SHALL be: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 The ports SHALL be: rst  in  1  reset; asynchronous and active-high.
REQ-004 The ports SHALL be: inst_read  in  1, inst_addr  in  32, inst_resp  out  1, inst_rdata  out  32; this is the CPU instruction port.
REQ-005 The ports SHALL be: data_read  in  1, data_write  in  1, data_mbe  in  4, data_addr  in  32, data_wdata  in  32, data_resp  out  1, data_rdata  out  32; this is the CPU data port.
REQ-006 The ports SHALL be: mem_read  out  1, mem_write  out  1, mem_mbe  out  4, mem_addr  out  32, mem_wdata  out  32, mem_resp  in  1, mem_rdata  in  32; this is the single shared memory port.

Function
REQ-007 The block SHALL have three states, IDLE, INST and DATA, with one transaction outstanding at most.
REQ-008 In IDLE, the block SHALL sample requests on each rising edge; a data request means data_read or data_write is high.
REQ-009 Arbitration in IDLE SHALL proceed in this order:
- data request pending and (starve_cnt < STARVE_LIMIT or inst_read low): go to DATA.
- otherwise, inst_read high: go to INST.
- otherwise: stay in IDLE.
REQ-010 On a grant, the block SHALL latch the winner's address into an internal request register; for a data grant it SHALL also latch data_wdata, data_mbe and the read/write kind.
REQ-011 mem_addr, mem_wdata, mem_mbe, mem_read and mem_write SHALL be driven only from that register, never combinationally from the CPU inputs.
REQ-012 While in INST or DATA, the block SHALL hold mem_read or mem_write high with constant mem_addr, mem_mbe and mem_wdata until the cycle mem_resp is high.
REQ-013 For reads, mem_mbe SHALL be 4'hF; for writes, mem_mbe SHALL equal the latched data_mbe.
REQ-014 If data_read and data_write are both high at grant, the block SHALL treat the request as a write only.
REQ-015 In a cycle with mem_resp high, the block SHALL behave as follows:
- the owner's resp output SHALL be high for exactly that cycle.
- the owner's rdata output SHALL equal mem_rdata combinationally.
- the next state SHALL be IDLE.
REQ-016 inst_resp SHALL be high only in INST with mem_resp high; data_resp SHALL be high only in DATA with mem_resp high.
REQ-017 inst_rdata and data_rdata SHALL be 0 whenever the corresponding resp output is low.
REQ-018 mem_resp received in IDLE SHALL be ignored; no CPU resp output SHALL assert and the state SHALL not change.
REQ-019 Latency SHALL be as follows:
- request sampled in IDLE at edge T: memory request visible after edge T.
- earliest CPU resp: in the cycle after T, when memory responds immediately.
- IDLE is mandatory for one cycle between transactions, so back-to-back grants are separated by at least one IDLE cycle.
REQ-020 A CPU request that drops mid-transaction SHALL NOT abort the memory transaction; the transaction SHALL complete and the resp pulse SHALL still be issued.
REQ-021 The starvation counter starve_cnt SHALL be 2 bits wide, sized for STARVE_LIMIT of 3 or less, and SHALL update as follows:
- increments on each DATA grant while inst_read is high.
- saturates at STARVE_LIMIT.
- clears to 0 on each INST grant.
- otherwise holds.
REQ-022 When starve_cnt equals STARVE_LIMIT and both requests are pending, the block SHALL grant INST.

Reset
REQ-023 While rst is high, asynchronously and regardless of state, the block SHALL force the following:
- state = IDLE, starve_cnt = 0, request register cleared.
- mem_read, mem_write, inst_resp and data_resp = 0.
- mem_addr, mem_wdata and mem_mbe = 0.
- inst_rdata and data_rdata = 0.
REQ-024 If rst asserts mid-transaction, the in-flight transaction SHALL be abandoned with no CPU resp issued, and a late mem_resp after reset SHALL be ignored per REQ-018.

Verification
REQ-025 The bench SHALL cover an instruction read: inst_read=1, inst_addr=0x60 and mem_resp after 3 cycles with mem_rdata=0x00000013 -> mem_read=1 and mem_addr=0x60 held for 3 cycles, then a single inst_resp pulse with inst_rdata=0x00000013.
REQ-026 The bench SHALL cover a data write: data_write=1, data_addr=0x100, data_wdata=0xDEADBEEF, data_mbe=4'b0011 -> mem_write=1 with mem_mbe=4'b0011 and mem_wdata=0xDEADBEEF; data_resp pulses with mem_resp; inst_resp stays 0.
REQ-027 The bench SHALL cover a simultaneous request: inst_read and data_read rise in the same cycle -> DATA granted first; INST is granted after the intervening IDLE cycle.
REQ-028 The bench SHALL cover starvation: inst_read held high while data requests repeat continuously -> exactly 3 DATA grants, then an INST grant, after which starve_cnt = 0.
REQ-029 The bench SHALL cover reset mid-transaction: rst pulsed while in DATA with mem_resp still pending -> mem_write falls asynchronously; a subsequent mem_resp produces no data_resp.
REQ-030 The bench SHALL cover a request withdrawn mid-transaction: inst_read deasserted during INST -> mem_read stays high until mem_resp, and inst_resp still pulses once.
